// File: rtl/roba_seq_divider_if.sv
// Handshake bundle for roba_seq_divider: operand channel in, result channel out.
interface roba_seq_divider_if #(
  parameter int N_BW = 64,
  parameter int D_BW = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [N_BW-1:0] dividend;
  logic [D_BW-1:0] divisor;
  logic            out_valid;
  logic            out_ready;
  logic [N_BW-1:0] quotient;
  logic [D_BW-1:0] remainder;
  logic            div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/roba_seq_divider.sv
// Sequential restoring divider: normalises the dividend to its leading one, then
// retires one quotient bit per cycle, so latency scales with the dividend magnitude.
module roba_seq_divider #(
  parameter int N_BW = 64,
  parameter int D_BW = 32,
  parameter int N_LG = $clog2(N_BW)
) (
  input  logic              clk,
  input  logic              rst,
  roba_seq_divider_if.slave bus
);

  typedef enum logic [1:0] {IDLE, NORM, CALC, DONE} state_t;

  state_t          state_r, state_nxt_s;
  logic [N_BW-1:0] dvd_r;
  logic [D_BW-1:0] dvs_r;
  logic [D_BW-1:0] pr_r;
  logic [N_BW-1:0] quo_r;
  logic [N_LG-1:0] cnt_r;
  logic            dbz_r;
  logic            in_ready_r;
  logic            out_valid_r;

  logic [N_LG-1:0] k_s;
  logic [N_LG-1:0] shamt_s;
  logic [D_BW:0]   pr_sh_s;
  logic            ge_s;
  logic [D_BW-1:0] pr_nxt_s;

  function automatic logic [N_LG-1:0] lead_one(input logic [N_BW-1:0] v);
    logic [N_LG-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_BW; i++) begin
      if (v[i]) idx = N_LG'(i);
    end
    return idx;
  endfunction

  // Leading-one normalisation and one restoring-division step.
  // The stored remainder is always below the divisor, so D_BW bits hold it;
  // only the shifted trial value needs the extra bit.
  always_comb begin
    k_s      = lead_one(dvd_r);
    shamt_s  = N_LG'(N_BW - 1) - k_s;
    pr_sh_s  = {pr_r, dvd_r[N_BW-1]};
    ge_s     = (pr_sh_s >= {1'b0, dvs_r});
    if (ge_s) begin
      pr_nxt_s = D_BW'(pr_sh_s - {1'b0, dvs_r});
    end else begin
      pr_nxt_s = pr_sh_s[D_BW-1:0];
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) state_nxt_s = NORM;
        else              state_nxt_s = IDLE;
      end
      NORM: begin
        if ((dvs_r == '0) || (dvd_r == '0)) state_nxt_s = DONE;
        else                                state_nxt_s = CALC;
      end
      CALC: begin
        if (cnt_r == '0) state_nxt_s = DONE;
        else             state_nxt_s = CALC;
      end
      DONE: begin
        if (bus.out_ready) state_nxt_s = IDLE;
        else               state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Operand, partial remainder, quotient and handshake registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_r       <= '0;
      dvs_r       <= '0;
      pr_r        <= '0;
      quo_r       <= '0;
      cnt_r       <= '0;
      dbz_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == DONE);
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            dvd_r <= bus.dividend;
            dvs_r <= bus.divisor;
            dbz_r <= 1'b0;
          end
        end
        NORM: begin
          if (dvs_r == '0) begin
            quo_r <= '1;
            pr_r  <= dvd_r[D_BW-1:0];
            dbz_r <= 1'b1;
          end else if (dvd_r == '0) begin
            quo_r <= '0;
            pr_r  <= '0;
          end else begin
            dvd_r <= dvd_r << shamt_s;
            pr_r  <= '0;
            quo_r <= '0;
            cnt_r <= k_s;
          end
        end
        CALC: begin
          dvd_r <= dvd_r << 1;
          pr_r  <= pr_nxt_s;
          quo_r <= {quo_r[N_BW-2:0], ge_s};
          if (cnt_r != '0) cnt_r <= cnt_r - N_LG'(1);
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.quotient    = quo_r;
  assign bus.remainder   = pr_r;
  assign bus.div_by_zero = dbz_r;

endmodule
